// File: rtl/ctrl_store_pkg.sv
// Shared definitions for the writable control store: microword field layout,
// default microword and the clear-engine state encoding.
package ctrl_store_pkg;

    localparam int MW_W = 64;

    localparam int MW_N_HI   = 57;
    localparam int MW_N_LO   = 55;
    localparam int MW_INV    = 54;
    localparam int MW_MI     = 53;
    localparam int MW_S_HI   = 52;
    localparam int MW_S_LO   = 50;
    localparam int MW_CR_HI  = 49;
    localparam int MW_CR_LO  = 34;
    localparam int MW_LD_HI  = 33;
    localparam int MW_LD_LO  = 26;
    localparam int MW_MUX_HI = 25;
    localparam int MW_MUX_LO = 18;
    localparam int MW_OP_HI  = 17;
    localparam int MW_OP_LO  = 13;

    // Packed view of the microword, MSB first, matching the bit positions above.
    typedef struct packed {
        logic [5:0]  reserved;
        logic [2:0]  n;
        logic        inv;
        logic        mi;
        logic [2:0]  s;
        logic [15:0] cr;
        logic [7:0]  ld;
        logic [7:0]  mux;
        logic [4:0]  alu_op;
        logic [12:0] spare;
    } microword_t;

    localparam logic [MW_W-1:0] CS_DEFAULT_WORD = '0;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } cs_state_t;

    function automatic logic [4:0] mw_alu_op(input microword_t w);
        return w.alu_op;
    endfunction

endpackage

// File: rtl/ctrl_store_if.sv
// Read / patch-write / clear bundle between the microsequencer (master) and
// the control store (slave).
interface ctrl_store_if #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 64
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_miss;
    logic              rd_perr;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;

    logic              clr_start;
    logic              busy;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, clr_start,
        input  rd_ready, rd_data, rd_valid, rd_miss, rd_perr, busy
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, clr_start,
        output rd_ready, rd_data, rd_valid, rd_miss, rd_perr, busy
    );
endinterface

// File: rtl/ctrl_store_ram.sv
// Microword array: synchronous write, combinational read. The parent owns the
// read register, the valid bitmap and all control.
module ctrl_store_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ctrl_store.sv
// Writable control store: registered read with handshake, patch port, valid
// tracking and sequential clear. Define CTRL_STORE_PARITY_EN for per-entry parity.
module ctrl_store #(
    parameter int               ADDR_W       = 8,
    parameter int               WORD_W       = 64,
    parameter logic [WORD_W-1:0] DEFAULT_WORD = WORD_W'(ctrl_store_pkg::CS_DEFAULT_WORD),
    parameter bit               INIT_VALID   = 1'b0
) (
    input logic         clk,
    input logic         reset_n,
    ctrl_store_if.slave bus
);
    import ctrl_store_pkg::*;

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);
`ifdef CTRL_STORE_PARITY_EN
    localparam int RAM_W = WORD_W + 1;
`else
    localparam int RAM_W = WORD_W;
`endif

    cs_state_t         state_q, state_d;
    logic [ADDR_W:0]   clr_cnt_q;
    logic [DEPTH-1:0]  valid_q;

    logic              rd_ready;
    logic              busy;
    logic              wr_accept;
    logic              clr_step;
    logic              rd_accept;
    logic              fwd_hit;
    logic              entry_valid;

    logic [RAM_W-1:0]  ram_wdata;
    logic [RAM_W-1:0]  ram_rdata;

    logic [WORD_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              rd_miss_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.clr_start) state_d = CLEAR;
            CLEAR:   if (clr_cnt_q == LAST_CNT) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_ready  = 1'b0;
        busy      = 1'b0;
        clr_step  = 1'b0;
        wr_accept = 1'b0;
        case (state_q)
            IDLE: begin
                rd_ready  = 1'b1;
                wr_accept = bus.wr_en;
            end
            CLEAR: begin
                busy     = 1'b1;
                clr_step = 1'b1;
            end
            default: ;
        endcase
    end

    // The counter is one bit wider than the address so DEPTH-1 is unambiguous.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_cnt_q <= '0;
        end else if (clr_step) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
        end else begin
            clr_cnt_q <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= {DEPTH{INIT_VALID}};
        end else if (clr_step) begin
            valid_q[clr_cnt_q[ADDR_W-1:0]] <= 1'b0;
        end else if (wr_accept) begin
            valid_q[bus.wr_addr] <= 1'b1;
        end
    end

    // Write-first: a same-cycle write to the read address is forwarded.
    assign rd_accept   = bus.rd_en && rd_ready;
    assign fwd_hit     = wr_accept && (bus.wr_addr == bus.rd_addr);
    assign entry_valid = valid_q[bus.rd_addr] || fwd_hit;

    ctrl_store_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (RAM_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (bus.wr_addr),
        .wdata (ram_wdata),
        .raddr (bus.rd_addr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q  <= DEFAULT_WORD;
            rd_valid_q <= 1'b0;
            rd_miss_q  <= 1'b0;
        end else begin
            rd_valid_q <= rd_accept;
            rd_miss_q  <= rd_accept && !entry_valid;
            if (rd_accept) begin
                if (fwd_hit) begin
                    rd_data_q <= bus.wr_data;
                end else if (entry_valid) begin
                    rd_data_q <= ram_rdata[WORD_W-1:0];
                end else begin
                    rd_data_q <= DEFAULT_WORD;
                end
            end
        end
    end

`ifdef CTRL_STORE_PARITY_EN
    logic rd_perr_q;

    // Stored bit makes the whole entry even; forwarded and missing words are never flagged.
    assign ram_wdata = {^bus.wr_data, bus.wr_data};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_perr_q <= 1'b0;
        end else begin
            rd_perr_q <= rd_accept && entry_valid && !fwd_hit && (^ram_rdata);
        end
    end

    assign bus.rd_perr = rd_perr_q;
`else
    assign ram_wdata   = bus.wr_data;
    assign bus.rd_perr = 1'b0;
`endif

    assign bus.rd_ready = rd_ready;
    assign bus.busy     = busy;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_miss  = rd_miss_q;

endmodule

// File: tb/tb_ctrl_store.sv
// Bench for ctrl_store: reference model of the store plus directed and random
// traffic; a second instance covers INIT_VALID=1.
module tb_ctrl_store;
    import ctrl_store_pkg::*;

    localparam int ADDR_W = 8;
    localparam int WORD_W = 64;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    ctrl_store_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus  ();
    ctrl_store_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus2 ();

    ctrl_store #(
        .ADDR_W       (ADDR_W),
        .WORD_W       (WORD_W),
        .DEFAULT_WORD ('0),
        .INIT_VALID   (1'b0)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    ctrl_store #(
        .ADDR_W       (ADDR_W),
        .WORD_W       (WORD_W),
        .DEFAULT_WORD ('0),
        .INIT_VALID   (1'b1)
    ) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    int passed = 0;
    int total  = 0;

    logic [63:0] m_mem   [DEPTH];
    bit          m_valid [DEPTH];
    bit          m_bad   [DEPTH];
    int          clear_left = 0;
    logic [63:0] exp_data   = '0;
    bit          exp_valid  = 1'b0;
    bit          exp_miss   = 1'b0;
    bit          exp_perr   = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [7:0] ra, input logic w,
                                 input logic [7:0] wa, input logic [63:0] wd,
                                 input logic c);
        bus.rd_en      = r;   bus2.rd_en     = r;
        bus.rd_addr    = ra;  bus2.rd_addr   = ra;
        bus.wr_en      = w;   bus2.wr_en     = w;
        bus.wr_addr    = wa;  bus2.wr_addr   = wa;
        bus.wr_data    = wd;  bus2.wr_data   = wd;
        bus.clr_start  = c;   bus2.clr_start = c;
        @(posedge clk);
        #1;
        bus.rd_en     = 1'b0; bus2.rd_en     = 1'b0;
        bus.wr_en     = 1'b0; bus2.wr_en     = 1'b0;
        bus.clr_start = 1'b0; bus2.clr_start = 1'b0;
    endtask

    // Reference model: a clear wipes the whole store at once and then simply
    // blocks the port for DEPTH cycles, since no read can observe the sweep.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
            clear_left = 0;
            exp_valid  = 1'b0;
            exp_miss   = 1'b0;
            exp_perr   = 1'b0;
            exp_data   = '0;
        end else if (clear_left != 0) begin
            clear_left--;
            exp_valid = 1'b0;
            exp_miss  = 1'b0;
            exp_perr  = 1'b0;
        end else begin
            exp_valid = bus.rd_en;
            exp_miss  = 1'b0;
            exp_perr  = 1'b0;
            if (bus.rd_en) begin
                if (bus.wr_en && bus.wr_addr == bus.rd_addr) begin
                    exp_data = bus.wr_data;
                end else if (m_valid[bus.rd_addr]) begin
                    exp_data = m_mem[bus.rd_addr];
                    exp_perr = m_bad[bus.rd_addr];
                end else begin
                    exp_data = '0;
                    exp_miss = 1'b1;
                end
            end
            if (bus.wr_en) begin
                m_mem[bus.wr_addr]   = bus.wr_data;
                m_valid[bus.wr_addr] = 1'b1;
                m_bad[bus.wr_addr]   = 1'b0;
            end
            if (bus.clr_start) begin
                for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
                clear_left = DEPTH;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            checkOutput("cmp_rd_valid", 64'(bus.rd_valid), 64'(exp_valid));
            checkOutput("cmp_rd_miss",  64'(bus.rd_miss),  64'(exp_miss));
            checkOutput("cmp_rd_perr",  64'(bus.rd_perr),  64'(exp_perr));
            checkOutput("cmp_rd_data",  bus.rd_data,       exp_data);
            checkOutput("cmp_rd_ready", 64'(bus.rd_ready), 64'(clear_left == 0));
            checkOutput("cmp_busy",     64'(bus.busy),     64'(clear_left != 0));
        end
    end

    initial begin
        int n;
        bus.rd_en = 1'b0;  bus.rd_addr = '0;  bus.wr_en = 1'b0;  bus.wr_addr = '0;
        bus.wr_data = '0;  bus.clr_start = 1'b0;
        bus2.rd_en = 1'b0; bus2.rd_addr = '0; bus2.wr_en = 1'b0; bus2.wr_addr = '0;
        bus2.wr_data = '0; bus2.clr_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_bad[i] = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rd_valid", 64'(bus.rd_valid), 64'd0);
        checkOutput("reset_rd_miss",  64'(bus.rd_miss),  64'd0);
        checkOutput("reset_busy",     64'(bus.busy),     64'd0);
        checkOutput("reset_rd_data",  bus.rd_data,       64'd0);
        checkOutput("reset_rd_perr",  64'(bus.rd_perr),  64'd0);
        reset_n = 1'b1;

        applyStimulus(1'b1, 8'd5, 1'b0, 8'd0, 64'd0, 1'b0);
        checkOutput("miss5_valid", 64'(bus.rd_valid), 64'd1);
        checkOutput("miss5_miss",  64'(bus.rd_miss),  64'd1);
        checkOutput("miss5_data",  bus.rd_data,       64'd0);
        checkOutput("init1_miss5", 64'(bus2.rd_miss), 64'd0);

        applyStimulus(1'b0, 8'd0, 1'b1, 8'd16, 64'h4210_A870_6440_4000, 1'b0);
        applyStimulus(1'b1, 8'd16, 1'b0, 8'd0, 64'd0, 1'b0);
        checkOutput("rd16_data", bus.rd_data,      64'h4210_A870_6440_4000);
        checkOutput("rd16_miss", 64'(bus.rd_miss), 64'd0);

        applyStimulus(1'b1, 8'd3, 1'b1, 8'd3, 64'hDEAD_BEEF_0000_0001, 1'b0);
        checkOutput("fwd3_data", bus.rd_data,      64'hDEAD_BEEF_0000_0001);
        checkOutput("fwd3_miss", 64'(bus.rd_miss), 64'd0);
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 64'd0, 1'b0);
        checkOutput("hold_valid", 64'(bus.rd_valid), 64'd0);
        checkOutput("hold_data",  bus.rd_data,       64'hDEAD_BEEF_0000_0001);

        applyStimulus(1'b0, 8'd0, 1'b1, 8'd0,   64'h1111_2222_3333_4444, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b1, 8'd255, 64'h5555_6666_7777_8888, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 64'd0, 1'b1);
        checkOutput("clr_busy",  64'(bus.busy),     64'd1);
        checkOutput("clr_ready", 64'(bus.rd_ready), 64'd0);
        n = 0;
        while (bus.busy && n < 1000) begin
            applyStimulus(1'b1, 8'd0, 1'b1, 8'd0, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0);
            n++;
        end
        checkOutput("clr_busy_cycles", 64'(n), 64'd256);
        applyStimulus(1'b1, 8'd0, 1'b0, 8'd0, 64'd0, 1'b0);
        checkOutput("clr_miss0", 64'(bus.rd_miss), 64'd1);
        applyStimulus(1'b1, 8'd255, 1'b0, 8'd0, 64'd0, 1'b0);
        checkOutput("clr_miss255", 64'(bus.rd_miss), 64'd1);

        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 64'd0, 1'b1);
        repeat (100) applyStimulus(1'b1, 8'd9, 1'b0, 8'd0, 64'd0, 1'b0);
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_busy",      64'(bus.busy),      64'd0);
        checkOutput("midrst_rd_valid",  64'(bus.rd_valid),  64'd0);
        checkOutput("midrst_busy2",     64'(bus2.busy),     64'd0);
        checkOutput("midrst_rd_valid2", 64'(bus2.rd_valid), 64'd0);
        #1;
        reset_n = 1'b1;
        applyStimulus(1'b1, 8'd0, 1'b0, 8'd0, 64'd0, 1'b0);
        checkOutput("init1_valid0", 64'(bus2.rd_valid), 64'd1);
        checkOutput("init1_miss0",  64'(bus2.rd_miss),  64'd0);
        applyStimulus(1'b1, 8'd200, 1'b0, 8'd0, 64'd0, 1'b0);
        checkOutput("init1_miss200", 64'(bus2.rd_miss), 64'd0);
        checkOutput("init0_miss200", 64'(bus.rd_miss),  64'd1);

        for (int i = 0; i < 1500; i++) begin
            logic [7:0] ra, wa;
            ra = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            wa = 8'($urandom_range(0, 15));
            applyStimulus(1'($urandom), ra, ($urandom_range(0, 2) == 0), wa,
                          {$urandom, $urandom}, ($urandom_range(0, 299) == 0));
        end

        n = 0;
        while (bus.busy && n < 400) begin
            applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 64'd0, 1'b0);
            n++;
        end
        checkOutput("drain_busy", 64'(bus.busy), 64'd0);

`ifdef CTRL_STORE_PARITY_EN
        applyStimulus(1'b0, 8'd0, 1'b1, 8'd20, 64'h0123_4567_89AB_CDEF, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b1, 8'd21, 64'hFEDC_BA98_7654_3210, 1'b0);
        dut.u_ram.mem[20][7] = ~dut.u_ram.mem[20][7];
        m_mem[20][7] = ~m_mem[20][7];
        m_bad[20] = 1'b1;
        applyStimulus(1'b1, 8'd20, 1'b0, 8'd0, 64'd0, 1'b0);
        checkOutput("perr20", 64'(bus.rd_perr), 64'd1);
        checkOutput("perr20_data", bus.rd_data, 64'h0123_4567_89AB_CD6F);
        applyStimulus(1'b1, 8'd21, 1'b0, 8'd0, 64'd0, 1'b0);
        checkOutput("perr21", 64'(bus.rd_perr), 64'd0);
`endif

        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 64'd0, 1'b0);
        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
